gpio_pad_cfg_sequencer: RTL

GPIO_PAD_CFG_SEQUENCER -- requirements
Module: gpio_pad_cfg_sequencer

---
 rtl/gpio_pad_cfg_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gpio_pad_cfg_sequencer.sv
// Shadow/live GPIO pad configuration store with a paced apply sequencer that
// copies one pad per LOAD cycle from the shadow array into the live outputs.
module gpio_pad_cfg_sequencer #(
    parameter int unsigned NUM_PADS      = 44,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [10:0] RESET_CFG     = 11'h100
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [5:0]          cfg_pad,
    input  logic [10:0]         cfg_data,
    output logic                cfg_err,
    input  logic                apply_req,
    output logic                busy,
    output logic                done,
    output logic [5:0]          cur_pad,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic [NUM_PADS-1:0] gpio_analog_pol,
    output logic [NUM_PADS-1:0] gpio_analog_sel,
    output logic [NUM_PADS-1:0] gpio_analog_en,
    output logic [NUM_PADS-1:0] gpio_holdover,
    output logic [NUM_PADS-1:0] gpio_slow_sel,
    output logic [NUM_PADS-1:0] gpio_vtrip_sel,
    output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
    output logic [NUM_PADS-1:0] gpio_inp_dis
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

    localparam logic [5:0] LAST_PAD    = 6'(NUM_PADS - 1);
    localparam logic [6:0] PAD_LIMIT   = 7'(NUM_PADS);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t state, state_next;

    logic [NUM_PADS-1:0][10:0] shadow;
    logic [NUM_PADS-1:0][10:0] live;
    logic [3:0]                settle_cnt;
    logic                      last_pad;
    logic                      write_fire;
    logic                      pad_ok;

    assign cfg_ready  = (state == IDLE);
    assign busy       = (state == LOAD) || (state == SETTLE);
    assign done       = (state == DONE);
    assign last_pad   = (cur_pad == LAST_PAD);
    assign write_fire = cfg_valid && cfg_ready;
    assign pad_ok     = ({1'b0, cfg_pad} < PAD_LIMIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (apply_req) state_next = LOAD;
            end
            LOAD: begin
                if (SETTLE_CYCLES != 0) state_next = SETTLE;
                else if (last_pad)      state_next = DONE;
                else                    state_next = LOAD;
            end
            SETTLE: begin
                if (settle_cnt == '0) state_next = last_pad ? DONE : LOAD;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow writes are only possible in IDLE, so the shadow is frozen while a sequence runs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shadow     <= {NUM_PADS{RESET_CFG}};
            live       <= {NUM_PADS{RESET_CFG}};
            cur_pad    <= '0;
            settle_cnt <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= write_fire && !pad_ok;
            if (write_fire && pad_ok) shadow[cfg_pad] <= cfg_data;
            case (state)
                IDLE: cur_pad <= '0;
                LOAD: begin
                    live[cur_pad] <= shadow[cur_pad];
                    if (SETTLE_CYCLES != 0) begin
                        settle_cnt <= SETTLE_INIT;
                    end else begin
                        cur_pad <= last_pad ? 6'd0 : cur_pad + 6'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        cur_pad <= last_pad ? 6'd0 : cur_pad + 6'd1;
                    end
                end
                DONE: cur_pad <= '0;
                default: cur_pad <= '0;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
        assign gpio_dm2[k]         = live[k][10];
        assign gpio_dm1[k]         = live[k][9];
        assign gpio_dm0[k]         = live[k][8];
        assign gpio_analog_pol[k]  = live[k][7];
        assign gpio_analog_sel[k]  = live[k][6];
        assign gpio_analog_en[k]   = live[k][5];
        assign gpio_holdover[k]    = live[k][4];
        assign gpio_slow_sel[k]    = live[k][3];
        assign gpio_vtrip_sel[k]   = live[k][2];
        assign gpio_ib_mode_sel[k] = live[k][1];
        assign gpio_inp_dis[k]     = live[k][0];
    end

endmodule
